// File: rtl/twos_decoder_serial_pkg.sv
// Shared definitions for the serial two's-complement / ones'-complement
// encoder and decoder family.
//   DEFAULT_WIDTH : default operand width
//   fsm_state_e   : IDLE / SHIFT / DONE sequencing shared by the serial blocks
package twos_decoder_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/twos_decoder_serial_bit_stage.sv
// Per-bit rule of serial two's-complement negation.
//   bit_in   : operand bit being processed (LSB first)
//   sign     : 1 = operand negative, negate; 0 = copy through
//   seen_in  : a 1 has already been seen at a lower bit position
//   bit_out  : magnitude bit for this position
//   seen_out : updated seen-one flag
module twos_bit_stage (
  input  logic bit_in,
  input  logic sign,
  input  logic seen_in,
  output logic bit_out,
  output logic seen_out
);

  always_comb begin
    // Bits up to and including the first 1 pass through; later bits invert.
    bit_out  = bit_in ^ (sign & seen_in);
    seen_out = seen_in | bit_in;
  end

endmodule

// File: rtl/twos_decoder_serial.sv
// Serial two's-complement to sign/magnitude decoder, one bit per clock.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (in_value), accepted only in IDLE
//   out_valid/out_ready  : result handshake (out_sign, out_mag), held in DONE
//   busy                 : high while bits are being shifted
//   dbg_state            : current FSM state, for observation only
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid-side data is held stable until that edge, ready may be
// asserted independently of valid.
module twos_decoder_serial
  import twos_decoder_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             busy,
  output fsm_state_e       dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  fsm_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             sign_q, sign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;

  logic             stage_bit_out;
  logic             stage_seen_out;

  twos_bit_stage u_bit_stage (
    .bit_in   (data_q[cnt_q]),
    .sign     (sign_q),
    .seen_in  (seen_q),
    .bit_out  (stage_bit_out),
    .seen_out (stage_seen_out)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)          state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  if (out_ready)         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    data_d = data_q;
    mag_d  = mag_q;
    sign_d = sign_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    if (state_q == ST_IDLE && in_valid) begin
      // Operand is captured so later in_value changes cannot disturb the result.
      data_d = in_value;
      sign_d = in_value[WIDTH-1];
      mag_d  = '0;
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      mag_d[cnt_q] = stage_bit_out;
      seen_d       = stage_seen_out;
      // Counter parks on the last bit instead of wrapping.
      if (cnt_q != LAST_BIT) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q == ST_SHIFT);
    out_valid = (state_q == ST_DONE);
    out_sign  = sign_q;
    out_mag   = mag_q;
    dbg_state = state_q;
  end

endmodule

// File: doc/twos_decoder_serial.md
TWOS_DECODER_SERIAL -- requirements
Module: twos_decoder_serial

Interface
REQ-001 SHALL have parameter: WIDTH, 8, bit width of the input word and the magnitude output.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  in_value holds a two's-complement word to decode.
REQ-005 SHALL have port: in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port: in_value  input  WIDTH  two's-complement operand.
REQ-007 SHALL have port: out_valid  output  1  sign/magnitude result available.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.
REQ-009 SHALL have port: out_sign  output  1  1 = negative operand.
REQ-010 SHALL have port: out_mag  output  WIDTH  unsigned magnitude |in_value|.
REQ-011 SHALL have port: busy  output  1  high while in SHIFT state.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in SHIFT.
REQ-014 SHALL accept a word on the edge where in_valid and in_ready are both 1: latch in_value, set out_sign=in_value[WIDTH-1], clear bit counter, clear "seen-one" flag, go to SHIFT.
REQ-015 SHALL process one bit per clock in SHIFT, LSB first, bit index = counter 0..WIDTH-1.
REQ-016 SHALL, for sign=0, copy each bit unchanged into magnitude position.
REQ-017 SHALL, for sign=1, copy bits up to and including the first 1, then invert every later bit (serial two's-complement negation); seen-one flag set on the first 1.
REQ-018 SHALL leave SHIFT for DONE on the edge that processes bit WIDTH-1; result valid WIDTH+1 edges after the accept edge.
REQ-019 SHALL hold out_sign and out_mag stable for the whole DONE state, regardless of out_ready.
REQ-020 SHALL return to IDLE on the edge where out_valid and out_ready are both 1; no new accept on that same edge.
REQ-021 SHALL ignore in_valid and in_value outside IDLE; changes to in_value after accept do not affect the result.
REQ-022 SHALL produce out_mag = 2^(WIDTH-1) with out_sign=1 for the most-negative operand (no overflow flag; fits in WIDTH bits).
REQ-023 SHALL produce out_sign=0, out_mag=0 for operand 0.
REQ-024 SHALL keep the bit counter WIDTH-agnostic ($clog2(WIDTH) bits), with no wrap beyond WIDTH-1.

Reset
REQ-025 SHALL, on reset high at a clock edge, force state IDLE, in_ready=1, out_valid=0, busy=0, out_sign=0, out_mag=0, counter=0, seen-one=0.
REQ-026 SHALL abort any SHIFT or DONE operation on reset with no result emitted; reset has priority over all handshakes.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, SHIFT, DONE) and the default WIDTH constant in a shared package, reusable by the ones/two's-complement encoder blocks.
REQ-028 SHALL isolate the per-bit rule (bit in, sign, seen-one in -> bit out, seen-one out) in one combinational sub-module named twos_bit_stage.

Verification
REQ-029 SHALL check: accept 8'hAA -> after 9 edges out_valid=1, out_sign=1, out_mag=8'h56.
REQ-030 SHALL check: 8'h80 -> out_sign=1, out_mag=8'h80; 8'hFF -> 1, 8'h01; 8'h00 -> 0, 8'h00; 8'h7F -> 0, 8'h7F.
REQ-031 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, then out_ready=1 -> IDLE next edge.
REQ-032 SHALL check: in_value changed and in_valid toggled during SHIFT -> result unaffected, no second accept.
REQ-033 SHALL check reset asserted at SHIFT bit 3 -> next edge IDLE, out_valid=0, out_mag=0; next word 8'hF6 decodes to 1, 8'h0A.
REQ-034 SHALL check back-to-back: in_valid held high with 8'h01 then 8'hFE -> two results 0/8'h01 and 1/8'h02, each WIDTH+1 edges after its accept.
